// File: rtl/ppi_mode1_handshake.sv
// ---------------------------------------------------------------------------
// ppi_mode1_handshake
//
// Mode 1 (strobed I/O) handshake controller for one group (A or B) of an
// 8255-style PPI. It snoops control-register writes (mode-set and BSR) to
// track mode, direction and INTE, then sequences STB/IBF/INTR for input or
// OBF/ACK/INTR for output, latching port data in each direction. The
// handshake outputs replace the BSR/CPU path on this group's Port C pins.
//
// Parameters:
//   GROUP_B     : 0 = group A decode (mode bits 6:5, dir bit 4,
//                 INTE = PC4 input / PC6 output);
//                 1 = group B decode (mode bit 2, dir bit 1, INTE = PC2)
//   DATA_W      : port data width
//   SYNC_STAGES : synchronizer depth on stb_n / ack_n (2..3)
//
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   cfg_wr, cfg_data    : control-register write pulse and control word
//   cpu_rd, cpu_wr      : CPU read / write pulses for this group's port
//   cpu_wdata           : CPU write data
//   port_in             : external port pins
//   stb_n, ack_n        : asynchronous active-low strobe / acknowledge
//   rdata, port_out     : latched input / output data
//   out_en              : drive port_out onto the pins
//   ibf, obf_n, intr    : handshake outputs
//   inte, mode1         : current INTE flag, group is in Mode 1
//   overrun             : sticky overrun flag
//
// Optional feature macro: PPI_HS_OVERRUN_EN
//   defined   : a strobe arriving while the input buffer is full sets
//               overrun (sticky until reset or mode-set)
//   undefined : overrun is tied to 0 and such a strobe is ignored
// ---------------------------------------------------------------------------
module ppi_mode1_handshake #(
    parameter bit GROUP_B     = 1'b0,
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_wr,
    input  logic [7:0]        cfg_data,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic [DATA_W-1:0] port_in,
    input  logic              stb_n,
    input  logic              ack_n,
    output logic [DATA_W-1:0] rdata,
    output logic [DATA_W-1:0] port_out,
    output logic              out_en,
    output logic              ibf,
    output logic              obf_n,
    output logic              intr,
    output logic              inte,
    output logic              mode1,
    output logic              overrun
);

    typedef enum logic [2:0] {
        S_OFF,
        S_IN_EMPTY,
        S_IN_FULL,
        S_OUT_EMPTY,
        S_OUT_FULL,
        S_OUT_ACK
    } state_t;

    state_t state;

    logic [SYNC_STAGES-1:0] stb_sync, ack_sync;
    logic stb_prev, ack_prev;
    logic stb_fall, stb_rise, ack_fall, ack_rise;
    logic dir_in;
    // Interrupt condition (strobe completed / acknowledge completed) kept
    // separately from intr so a later INTE set can raise intr on its own.
    logic int_cond;

    // Control-word decode for this group.
    logic       mode_set, bsr, bsr_hit;
    logic       cfg_mode1, cfg_dir_in;
    logic [2:0] inte_bit;

    assign mode_set   = cfg_wr & cfg_data[7];
    assign bsr        = cfg_wr & ~cfg_data[7];
    assign cfg_mode1  = GROUP_B ? cfg_data[2] : (cfg_data[6:5] == 2'b01);
    assign cfg_dir_in = GROUP_B ? cfg_data[1] : cfg_data[4];
    assign inte_bit   = GROUP_B ? 3'd2 : (dir_in ? 3'd4 : 3'd6);
    assign bsr_hit    = bsr && (cfg_data[3:1] == inte_bit) && (state != S_OFF);

    // Synchronizers plus registered edge pulses: the pulse is registered so
    // a pin edge first sampled at edge k acts at edge k+SYNC_STAGES+1.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value of its neighbours, like real hardware.
        if (reset) begin
            // Pins idle high, so the chain resets to 1 and no false edge
            // is seen when reset is released.
            stb_sync <= '1;
            ack_sync <= '1;
            stb_prev <= 1'b1;
            ack_prev <= 1'b1;
            stb_fall <= 1'b0;
            stb_rise <= 1'b0;
            ack_fall <= 1'b0;
            ack_rise <= 1'b0;
        end else begin
            stb_sync <= {stb_sync[SYNC_STAGES-2:0], stb_n};
            ack_sync <= {ack_sync[SYNC_STAGES-2:0], ack_n};
            stb_prev <= stb_sync[SYNC_STAGES-1];
            ack_prev <= ack_sync[SYNC_STAGES-1];
            stb_fall <= ~stb_sync[SYNC_STAGES-1] &  stb_prev;
            stb_rise <=  stb_sync[SYNC_STAGES-1] & ~stb_prev;
            ack_fall <= ~ack_sync[SYNC_STAGES-1] &  ack_prev;
            ack_rise <=  ack_sync[SYNC_STAGES-1] & ~ack_prev;
        end
    end

`ifdef PPI_HS_OVERRUN_EN
    logic overrun_q;
    assign overrun = overrun_q;
`else
    assign overrun = 1'b0;
`endif

    // Handshake FSM; all outputs are registered. cfg_wr outranks every
    // other event in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_OFF;
            rdata    <= '0;
            port_out <= '0;
            out_en   <= 1'b0;
            ibf      <= 1'b0;
            obf_n    <= 1'b1;
            intr     <= 1'b0;
            inte     <= 1'b0;
            mode1    <= 1'b0;
            dir_in   <= 1'b0;
            int_cond <= 1'b0;
`ifdef PPI_HS_OVERRUN_EN
            overrun_q <= 1'b0;
`endif
        end else if (mode_set) begin
            // rdata / port_out are deliberately held across a mode change.
            mode1    <= cfg_mode1;
            dir_in   <= cfg_dir_in;
            out_en   <= cfg_mode1 & ~cfg_dir_in;
            ibf      <= 1'b0;
            obf_n    <= 1'b1;
            intr     <= 1'b0;
            inte     <= 1'b0;
            int_cond <= 1'b0;
`ifdef PPI_HS_OVERRUN_EN
            overrun_q <= 1'b0;
`endif
            if (!cfg_mode1)     state <= S_OFF;
            else if (cfg_dir_in) state <= S_IN_EMPTY;
            else                 state <= S_OUT_EMPTY;
        end else if (bsr) begin
            if (bsr_hit) begin
                inte <= cfg_data[0];
                intr <= cfg_data[0] & int_cond;
            end
        end else begin
            case (state)
                S_IN_EMPTY: begin
                    if (stb_fall) begin
                        rdata <= port_in;
                        ibf   <= 1'b1;
                        state <= S_IN_FULL;
                    end
                end
                S_IN_FULL: begin
                    if (cpu_rd) begin
                        // Read empties the buffer first; a simultaneous
                        // strobe then refills it with the new byte.
                        intr     <= 1'b0;
                        int_cond <= 1'b0;
                        if (stb_fall) begin
                            rdata <= port_in;
                        end else begin
                            ibf   <= 1'b0;
                            state <= S_IN_EMPTY;
                        end
                    end else begin
                        if (stb_rise) begin
                            int_cond <= 1'b1;
                            intr     <= inte;
                        end
`ifdef PPI_HS_OVERRUN_EN
                        if (stb_fall) overrun_q <= 1'b1;
`endif
                    end
                end
                S_OUT_EMPTY, S_OUT_FULL, S_OUT_ACK: begin
                    if (cpu_wr) begin
                        port_out <= cpu_wdata;
                        obf_n    <= 1'b0;
                        intr     <= 1'b0;
                        int_cond <= 1'b0;
                        state    <= S_OUT_FULL;
                    end else if (state == S_OUT_FULL && ack_fall) begin
                        obf_n <= 1'b1;
                        state <= S_OUT_ACK;
                    end else if (state == S_OUT_ACK && ack_rise) begin
                        intr     <= inte;
                        int_cond <= 1'b1;
                        state    <= S_OUT_EMPTY;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ppi_mode1_handshake.sv
// ---------------------------------------------------------------------------
// Testbench for ppi_mode1_handshake: one group-A and one group-B instance
// share the control bus. Directed steps cover the handshake scenarios, then
// a randomized phase runs both groups against a behavioural model that
// tracks buffer/acknowledge status and a pin-sample delay line.
// ---------------------------------------------------------------------------
module tb_ppi_mode1_handshake;

    localparam int S = 2;       // synchronizer depth
    localparam int H = S + 2;   // pin history kept by the model

    logic       clk = 1'b0;
    logic       reset;
    logic       cfg_wr;
    logic [7:0] cfg_data;
    logic       rd_a, wr_a, rd_b, wr_b;
    logic [7:0] wdata, port_in;
    logic       stb_a_n, ack_a_n, stb_b_n, ack_b_n;

    logic [7:0] rdata_a, port_out_a, rdata_b, port_out_b;
    logic out_en_a, ibf_a, obf_n_a, intr_a, inte_a, mode1_a, overrun_a;
    logic out_en_b, ibf_b, obf_n_b, intr_b, inte_b, mode1_b, overrun_b;

    always #5 clk = ~clk;

    ppi_mode1_handshake #(.GROUP_B(1'b0), .DATA_W(8), .SYNC_STAGES(S)) dut_a (
        .clk(clk), .reset(reset), .cfg_wr(cfg_wr), .cfg_data(cfg_data),
        .cpu_rd(rd_a), .cpu_wr(wr_a), .cpu_wdata(wdata), .port_in(port_in),
        .stb_n(stb_a_n), .ack_n(ack_a_n), .rdata(rdata_a), .port_out(port_out_a),
        .out_en(out_en_a), .ibf(ibf_a), .obf_n(obf_n_a), .intr(intr_a),
        .inte(inte_a), .mode1(mode1_a), .overrun(overrun_a)
    );

    ppi_mode1_handshake #(.GROUP_B(1'b1), .DATA_W(8), .SYNC_STAGES(S)) dut_b (
        .clk(clk), .reset(reset), .cfg_wr(cfg_wr), .cfg_data(cfg_data),
        .cpu_rd(rd_b), .cpu_wr(wr_b), .cpu_wdata(wdata), .port_in(port_in),
        .stb_n(stb_b_n), .ack_n(ack_b_n), .rdata(rdata_b), .port_out(port_out_b),
        .out_en(out_en_b), .ibf(ibf_b), .obf_n(obf_n_b), .intr(intr_b),
        .inte(inte_b), .mode1(mode1_b), .overrun(overrun_b)
    );

    // ---------------- behavioural reference model ----------------
    typedef struct {
        bit mode1, dir_in, inte, ibf, obf, wait_rise, cond, intr, overrun;
        logic [7:0] rdata, port_out;
        logic [H-1:0] stb_h, ack_h;   // bit 0 = most recent pin sample
    } grp_t;

    grp_t ma, mb;

    function automatic grp_t model_reset();
        grp_t m;
        m.mode1 = 0; m.dir_in = 0; m.inte = 0; m.ibf = 0; m.obf = 0;
        m.wait_rise = 0; m.cond = 0; m.intr = 0; m.overrun = 0;
        m.rdata = 8'h00; m.port_out = 8'h00;
        m.stb_h = '1; m.ack_h = '1;
        return m;
    endfunction

    function automatic grp_t model_next(grp_t m, bit is_b, bit rst, bit cw,
                                        logic [7:0] cd, bit rd, bit wr,
                                        logic [7:0] wd, logic [7:0] pi,
                                        logic stb, logic ack);
        bit sfall, srise, afall, arise;
        logic [2:0] sel;
        if (rst) return model_reset();
        // A pin level sampled S+1 edges ago versus the one before it.
        sfall = (m.stb_h[S] == 1'b0) && (m.stb_h[S+1] == 1'b1);
        srise = (m.stb_h[S] == 1'b1) && (m.stb_h[S+1] == 1'b0);
        afall = (m.ack_h[S] == 1'b0) && (m.ack_h[S+1] == 1'b1);
        arise = (m.ack_h[S] == 1'b1) && (m.ack_h[S+1] == 1'b0);
        m.stb_h = {m.stb_h[H-2:0], stb};
        m.ack_h = {m.ack_h[H-2:0], ack};
        if (cw && cd[7]) begin
            m.mode1  = is_b ? cd[2] : (cd[6:5] == 2'b01);
            m.dir_in = is_b ? cd[1] : cd[4];
            m.ibf = 0; m.obf = 0; m.wait_rise = 0; m.cond = 0;
            m.intr = 0; m.inte = 0; m.overrun = 0;
        end else if (cw) begin
            sel = is_b ? 3'd2 : (m.dir_in ? 3'd4 : 3'd6);
            if (m.mode1 && cd[3:1] == sel) begin
                m.inte = cd[0];
                m.intr = cd[0] && m.cond;
            end
        end else if (m.mode1 && m.dir_in) begin
            if (!m.ibf) begin
                if (sfall) begin m.rdata = pi; m.ibf = 1; end
            end else if (rd) begin
                m.intr = 0; m.cond = 0; m.ibf = sfall;
                if (sfall) m.rdata = pi;
            end else begin
                if (srise) begin m.cond = 1; m.intr = m.inte; end
`ifdef PPI_HS_OVERRUN_EN
                if (sfall) m.overrun = 1;
`endif
            end
        end else if (m.mode1) begin
            if (wr) begin
                m.port_out = wd; m.obf = 1; m.wait_rise = 0;
                m.intr = 0; m.cond = 0;
            end else if (m.obf && afall) begin
                m.obf = 0; m.wait_rise = 1;
            end else if (m.wait_rise && arise) begin
                m.wait_rise = 0; m.cond = 1; m.intr = m.inte;
            end
        end
        return m;
    endfunction

    function automatic logic [22:0] exp_vec(grp_t m);
        return {m.rdata, m.port_out, m.mode1 & ~m.dir_in, m.ibf, ~m.obf,
                m.intr, m.inte, m.mode1, m.overrun};
    endfunction

    always @(posedge clk) begin
        ma = model_next(ma, 1'b0, reset, cfg_wr, cfg_data, rd_a, wr_a, wdata,
                        port_in, stb_a_n, ack_a_n);
        mb = model_next(mb, 1'b1, reset, cfg_wr, cfg_data, rd_b, wr_b, wdata,
                        port_in, stb_b_n, ack_b_n);
    end

    logic [22:0] obs_a, obs_b;
    assign obs_a = {rdata_a, port_out_a, out_en_a, ibf_a, obf_n_a, intr_a,
                    inte_a, mode1_a, overrun_a};
    assign obs_b = {rdata_b, port_out_b, out_en_b, ibf_b, obf_n_b, intr_b,
                    inte_b, mode1_b, overrun_b};

    // ---------------- checking helpers ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One clock; outputs are compared 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        check("model_grp_a", {9'd0, obs_a}, {9'd0, exp_vec(ma)});
        check("model_grp_b", {9'd0, obs_b}, {9'd0, exp_vec(mb)});
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic cfg(input logic [7:0] b);
        cfg_wr = 1'b1; cfg_data = b;
        step();
        cfg_wr = 1'b0;
    endtask

    task automatic stb_pulse_a(input logic [7:0] d);
        port_in = d; stb_a_n = 1'b0;
        steps(4);
        stb_a_n = 1'b1;
        steps(4);
    endtask

    task automatic stb_pulse_b(input logic [7:0] d);
        port_in = d; stb_b_n = 1'b0;
        steps(4);
        stb_b_n = 1'b1;
        steps(4);
    endtask

    logic [7:0] cfg_tab [12];
    localparam logic [22:0] RESET_VEC = 23'h000010;  // only obf_n = 1
`ifdef PPI_HS_OVERRUN_EN
    localparam logic OVR_EXP = 1'b1;
`else
    localparam logic OVR_EXP = 1'b0;
`endif

    initial begin
        cfg_tab = '{8'hB0, 8'hA0, 8'h86, 8'h84, 8'h80, 8'hC0,
                    8'h09, 8'h08, 8'h0D, 8'h0C, 8'h05, 8'h04};
        reset = 1'b1; cfg_wr = 1'b0; cfg_data = 8'h00;
        rd_a = 1'b0; wr_a = 1'b0; rd_b = 1'b0; wr_b = 1'b0;
        wdata = 8'h00; port_in = 8'h00;
        stb_a_n = 1'b1; ack_a_n = 1'b1; stb_b_n = 1'b1; ack_b_n = 1'b1;
        steps(2);
        check("reset_a", {9'd0, obs_a}, {9'd0, RESET_VEC});
        check("reset_b", {9'd0, obs_b}, {9'd0, RESET_VEC});
        reset = 1'b0;
        step();

        // Input handshake with INTE set; ibf must appear at edge k+3.
        cfg(8'hB0);
        check("mode1_in", {31'd0, mode1_a}, 32'd1);
        cfg(8'h09);
        check("inte_pc4", {31'd0, inte_a}, 32'd1);
        port_in = 8'h5A; stb_a_n = 1'b0;
        steps(3);
        check("ibf_early", {31'd0, ibf_a}, 32'd0);
        step();
        check("ibf_k3", {31'd0, ibf_a}, 32'd1);
        check("rdata_5a", {24'd0, rdata_a}, 32'h5A);
        stb_a_n = 1'b1;
        steps(3);
        check("intr_early", {31'd0, intr_a}, 32'd0);
        step();
        check("intr_rise", {31'd0, intr_a}, 32'd1);
        rd_a = 1'b1; step(); rd_a = 1'b0;
        check("rd_intr", {31'd0, intr_a}, 32'd0);
        check("rd_ibf", {31'd0, ibf_a}, 32'd0);

        // INTE clear during the strobe, then set afterwards.
        cfg(8'hB0);
        cfg(8'h08);
        stb_pulse_a(8'h3C);
        check("ibf_inte0", {31'd0, ibf_a}, 32'd1);
        check("intr_inte0", {31'd0, intr_a}, 32'd0);
        cfg(8'h09);
        check("intr_bsr", {31'd0, intr_a}, 32'd1);

        // Second strobe with the buffer still full.
        stb_pulse_a(8'h11);
        check("rdata_hold", {24'd0, rdata_a}, 32'h3C);
        check("overrun", {31'd0, overrun_a}, {31'd0, OVR_EXP});

        // Output handshake.
        cfg(8'hA0);
        cfg(8'h0D);
        wdata = 8'hC3; wr_a = 1'b1; step(); wr_a = 1'b0;
        check("port_out_c3", {24'd0, port_out_a}, 32'hC3);
        check("obf_low", {31'd0, obf_n_a}, 32'd0);
        check("out_en", {31'd0, out_en_a}, 32'd1);
        ack_a_n = 1'b0; steps(4);
        check("obf_ack", {31'd0, obf_n_a}, 32'd1);
        ack_a_n = 1'b1; steps(4);
        check("intr_ack", {31'd0, intr_a}, 32'd1);

        // Reset in S_OUT_FULL with ack held low.
        wdata = 8'h7E; wr_a = 1'b1; step(); wr_a = 1'b0;
        ack_a_n = 1'b0; reset = 1'b1;
        step();
        check("mid_reset", {9'd0, obs_a}, {9'd0, RESET_VEC});
        reset = 1'b0; ack_a_n = 1'b1;
        steps(4);

        // Group B input, then leave Mode 1.
        cfg(8'h86);
        cfg(8'h05);
        stb_pulse_b(8'hE7);
        check("b_intr", {31'd0, intr_b}, 32'd1);
        check("b_rdata", {24'd0, rdata_b}, 32'hE7);
        cfg(8'h80);
        check("b_off", {29'd0, intr_b, ibf_b, mode1_b}, 32'd0);
        stb_pulse_b(8'h42);
        check("b_ignored", {31'd0, ibf_b}, 32'd0);

        // Randomized phase against the model.
        for (int i = 0; i < 3000; i++) begin
            reset    = ($urandom_range(0, 499) == 0);
            cfg_wr   = ($urandom_range(0, 29) == 0);
            cfg_data = ($urandom_range(0, 5) == 0) ? 8'($urandom)
                                                  : cfg_tab[$urandom_range(0, 11)];
            rd_a     = ($urandom_range(0, 5) == 0);
            wr_a     = ($urandom_range(0, 7) == 0);
            rd_b     = ($urandom_range(0, 5) == 0);
            wr_b     = ($urandom_range(0, 7) == 0);
            wdata    = 8'($urandom);
            port_in  = 8'($urandom);
            if ($urandom_range(0, 3) == 0) stb_a_n = ~stb_a_n;
            if ($urandom_range(0, 3) == 0) ack_a_n = ~ack_a_n;
            if ($urandom_range(0, 3) == 0) stb_b_n = ~stb_b_n;
            if ($urandom_range(0, 3) == 0) ack_b_n = ~ack_b_n;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ppi_mode1_handshake.md
Name: ppi_mode1_handshake

Overview:
- Per-group Mode 1 (strobed I/O) handshake controller for the 8255 PPI.
- Decodes control-word writes (mode-set and BSR) to track mode, direction and INTE for one group (A or B).
- Sequences STB/IBF/INTR in input mode and OBF/ACK/INTR in output mode, and latches port data.
- Its handshake outputs are the values the Port C logic drives on that group's control pins in place of the BSR/CPU path.

Parameters:
- GROUP_B, 0, 0 = group A decode (mode bits 6:5, dir bit 4, INTE = PC4 input / PC6 output); 1 = group B decode (mode bit 2, dir bit 1, INTE = PC2).
- DATA_W, 8, port data width.
- SYNC_STAGES, 2, synchronizer flops on stb_n and ack_n (legal values 2..3).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- cfg_wr  input  1  one-cycle pulse: the CPU wrote the control register.
- cfg_data  input  8  control word; bit7=1 is mode-set, bit7=0 is BSR (bits 3:1 = PC bit, bit0 = set/clear).
- cpu_rd  input  1  one-cycle pulse: the CPU read this group's port.
- cpu_wr  input  1  one-cycle pulse: the CPU wrote this group's port.
- cpu_wdata  input  DATA_W  CPU write data.
- port_in  input  DATA_W  external port pins.
- stb_n  input  1  external strobe, active low, asynchronous.
- ack_n  input  1  external acknowledge, active low, asynchronous.
- rdata  output  DATA_W  latched input data.
- port_out  output  DATA_W  latched output data.
- out_en  output  1  1 = drive port_out onto the pins (Mode 1 output).
- ibf  output  1  input buffer full.
- obf_n  output  1  output buffer full, active low.
- intr  output  1  interrupt request.
- inte  output  1  current interrupt-enable flag.
- mode1  output  1  1 = this group is in Mode 1.
- overrun  output  1  sticky overrun flag (see Optional Feature).

Behaviour:
- Reset values: rdata=0, port_out=0, out_en=0, ibf=0, obf_n=1, intr=0, inte=0, mode1=0, overrun=0. Synchronizer flops and edge-detect registers reset to 1. State = S_OFF.
- Synchronizers: SYNC_STAGES flops, then a previous-value register.
  - fall = sync 0 and prev 1; rise = sync 1 and prev 0.
  - An event acts at the edge following its detection: a pin edge first sampled at edge k takes effect at edge k+SYNC_STAGES+1.
- Mode-set (cfg_wr with cfg_data[7]=1):
  - mode1 = 1 if the group mode field is 01 (group A: bits 6:5; group B: bit 2 = 1). Group A mode 1x is treated as not Mode 1.
  - dir_in is taken from the direction bit.
  - ibf=0, obf_n=1, intr=0, inte=0, overrun=0. rdata and port_out are held.
  - Next state: S_OFF if mode1=0; S_IN_EMPTY if input; otherwise S_OUT_EMPTY. out_en = mode1 & ~dir_in.
- BSR (cfg_wr with cfg_data[7]=0):
  - When cfg_data[3:1] selects this group's INTE bit for the current direction, inte = cfg_data[0].
  - If INTE is set while an interrupt condition already holds (S_IN_FULL after the stb rise, or S_OUT_EMPTY after an ack rise), intr=1 on the next edge.
  - Clearing INTE forces intr=0.
- States: S_OFF, S_IN_EMPTY, S_IN_FULL, S_OUT_EMPTY, S_OUT_FULL, S_OUT_ACK.
- S_OFF: all handshake outputs held at their reset values; pin events and cpu pulses are ignored.
- S_IN_EMPTY, on stb fall:
  - rdata <= port_in; ibf=1; go to S_IN_FULL.
- S_IN_FULL:
  - stb rise: intr=inte.
  - stb fall: overrun event; rdata is NOT overwritten.
  - cpu_rd: intr=0, ibf=0, go to S_IN_EMPTY.
  - cpu_rd and stb fall in the same cycle: read wins, then the new byte is latched; ibf stays 1 and rdata = new port_in.
- S_OUT_EMPTY / S_OUT_FULL / S_OUT_ACK, on cpu_wr:
  - port_out <= cpu_wdata; obf_n=0; intr=0; go to S_OUT_FULL.
  - A write in S_OUT_FULL overwrites port_out and does not change state.
- S_OUT_FULL, on ack fall:
  - obf_n=1; go to S_OUT_ACK.
- S_OUT_ACK, on ack rise:
  - intr=inte; go to S_OUT_EMPTY.
  - cpu_wr in the same cycle as the ack rise: the write wins (intr=0, obf_n=0, S_OUT_FULL).
- Pin events in the wrong direction are ignored.
- cfg_wr in the same cycle as any other event: cfg_wr takes priority.
- Reset mid-operation returns everything to the reset values regardless of pin levels.

Optional Feature:
- Macro PPI_HS_OVERRUN_EN.
- Defined: an overrun event sets overrun=1 (sticky). It is cleared only by reset or mode-set.
- Undefined: overrun is tied to 0, and a stb fall in S_IN_FULL is silently ignored.

Test Plan:
- Mode-set 8'hB0 (A mode 1, input), BSR 8'h09 (PC4 set), port_in=8'h5A, stb_n pulse low 4 cycles -> ibf=1 exactly 3 edges after the fall (SYNC_STAGES=2), rdata=8'h5A, intr=1 after the stb rise; cpu_rd -> intr=0, ibf=0 next edge.
- Same input configuration with BSR 8'h08 (INTE=0), stb pulse -> ibf=1, intr stays 0; then BSR 8'h09 -> intr=1 next edge.
- Mode-set 8'hA0 (A mode 1, output), BSR 8'h0D (PC6 set), cpu_wr 8'hC3 -> port_out=8'hC3, obf_n=0, out_en=1; ack_n low -> obf_n=1; ack_n high -> intr=1.
- Input mode with ibf=1, second stb with port_in=8'h11 -> rdata unchanged; overrun=1 with PPI_HS_OVERRUN_EN, 0 without.
- GROUP_B=1, mode-set 8'h86 (B mode 1, input), BSR 8'h05, stb -> intr=1; then mode-set 8'h80 -> intr=0, ibf=0, mode1=0, and further stb pulses are ignored.
- Mid-transfer in S_OUT_FULL, assert reset one cycle -> all outputs at reset values; obf_n=1, out_en=0.
